// File: rtl/motor_pwm_drive_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_drive_if
// Brief    : Steering command in, wheel PWM/duty/busy out.
// Revision : 1.0
// ============================================================================
interface motor_pwm_drive_if #(
  parameter int DUTY_W = 3
);
  logic              right;
  logic              left;
  logic              pwm_r;
  logic              pwm_l;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_l;
  logic              busy;

  modport master (output right, left, input  pwm_r, pwm_l, duty_r, duty_l, busy);
  modport slave  (input  right, left, output pwm_r, pwm_l, duty_r, duty_l, busy);
endinterface
`default_nettype wire

// File: rtl/motor_pwm_drive.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_drive
// Brief    : Two-wheel PWM drive with ramped duty; commands sampled per period.
//            Optional MOTOR_BRAKE_EN: stop command zeroes both duties at once.
// Revision : 1.0
// ============================================================================
module motor_pwm_drive #(
  parameter int DUTY_W       = 3,
  parameter int PRESCALE     = 4,
  parameter int RAMP_PERIODS = 2,
  parameter int DUTY_MAX     = 7,
  parameter int DUTY_MIN     = 2
) (
  input wire               clk,
  input wire               rst,
  motor_pwm_drive_if.slave bus
);

  localparam int                c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int                c_RAMP_W   = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(PRESCALE - 1);
  localparam logic [c_RAMP_W-1:0] c_RAMP_LAST = c_RAMP_W'(RAMP_PERIODS - 1);
  localparam logic [DUTY_W-1:0] c_CNT_LAST = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0] c_DUTY_MAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] c_DUTY_MIN = DUTY_W'(DUTY_MIN);

  logic [c_PRE_W-1:0]  r_pre;
  logic [DUTY_W-1:0]   r_cnt;
  logic [c_RAMP_W-1:0] r_ramp;
  logic [1:0]          r_cmd_q;
  logic [DUTY_W-1:0]   r_duty_r;
  logic [DUTY_W-1:0]   r_duty_l;
  logic                r_pwm_r;
  logic                r_pwm_l;
  logic                r_busy;

  logic                w_tick;
  logic                w_period_end;
  logic                w_ramp_step;
  logic                w_brake;
  logic [1:0]          w_cmd_nxt;
  logic [DUTY_W-1:0]   w_duty_r_nxt;
  logic [DUTY_W-1:0]   w_duty_l_nxt;

  function automatic logic [DUTY_W-1:0] f_tgt_r(input logic [1:0] cmd);
    case (cmd)
      2'b00:   f_tgt_r = c_DUTY_MAX;
      2'b10:   f_tgt_r = c_DUTY_MIN;
      2'b01:   f_tgt_r = c_DUTY_MAX;
      default: f_tgt_r = '0;
    endcase
  endfunction

  function automatic logic [DUTY_W-1:0] f_tgt_l(input logic [1:0] cmd);
    case (cmd)
      2'b00:   f_tgt_l = c_DUTY_MAX;
      2'b10:   f_tgt_l = c_DUTY_MAX;
      2'b01:   f_tgt_l = c_DUTY_MIN;
      default: f_tgt_l = '0;
    endcase
  endfunction

  // One unit toward the target; equality holds, so no over/undershoot.
  function automatic logic [DUTY_W-1:0] f_step(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
    if (cur < tgt)      f_step = cur + 1'b1;
    else if (cur > tgt) f_step = cur - 1'b1;
    else                f_step = cur;
  endfunction

  assign w_tick       = (r_pre == c_PRE_LAST);
  assign w_period_end = w_tick && (r_cnt == c_CNT_LAST);
  assign w_ramp_step  = w_period_end && (r_ramp == c_RAMP_LAST);
  assign w_cmd_nxt    = w_period_end ? {bus.right, bus.left} : r_cmd_q;

`ifdef MOTOR_BRAKE_EN
  assign w_brake = w_period_end && (w_cmd_nxt == 2'b11);
`else
  assign w_brake = 1'b0;
`endif

  always_comb begin
    w_duty_r_nxt = r_duty_r;
    w_duty_l_nxt = r_duty_l;
    if (w_brake) begin
      w_duty_r_nxt = '0;
      w_duty_l_nxt = '0;
    end else if (w_ramp_step) begin
      w_duty_r_nxt = f_step(r_duty_r, f_tgt_r(w_cmd_nxt));
      w_duty_l_nxt = f_step(r_duty_l, f_tgt_l(w_cmd_nxt));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre    <= '0;
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_cmd_q  <= 2'b11;
      r_duty_r <= '0;
      r_duty_l <= '0;
      r_pwm_r  <= 1'b0;
      r_pwm_l  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_period_end) begin
        r_ramp <= (r_ramp == c_RAMP_LAST) ? '0 : r_ramp + 1'b1;
      end
      r_cmd_q  <= w_cmd_nxt;
      r_duty_r <= w_duty_r_nxt;
      r_duty_l <= w_duty_l_nxt;
      // Compare on current registers: new duty shows from cnt=0 of next period.
      r_pwm_r  <= (r_cnt < r_duty_r);
      r_pwm_l  <= (r_cnt < r_duty_l);
      r_busy   <= (w_duty_r_nxt != f_tgt_r(w_cmd_nxt)) ||
                  (w_duty_l_nxt != f_tgt_l(w_cmd_nxt));
    end
  end

  assign bus.pwm_r  = r_pwm_r;
  assign bus.pwm_l  = r_pwm_l;
  assign bus.duty_r = r_duty_r;
  assign bus.duty_l = r_duty_l;
  assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: doc/motor_pwm_drive.md
Name: motor_pwm_drive

Overview:
- Consumes the `right`/`left` steering commands produced by the two-sensor steering FSM.
- Drives the two wheel motors: one PWM output per wheel, plus the current duty value and a ramp-busy flag.
- Duty cycles ramp one step at a time toward a per-command target, so direction changes never jerk the motors.
- Commands are sampled only at PWM period boundaries, so a pulse never changes shape mid-period.

Parameters:
- DUTY_W, 3: width of the duty registers and the PWM counter; the period is 2^DUTY_W counts.
- PRESCALE, 4: clock cycles per PWM count (≥1).
- RAMP_PERIODS, 2: PWM periods per ramp step (≥1).
- DUTY_MAX, 7: cruise duty (≤ 2^DUTY_W-1).
- DUTY_MIN, 2: inner-wheel duty while turning (< DUTY_MAX).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- right  input  1  steering command bit, synchronous to clk.
- left  input  1  steering command bit, synchronous to clk.
- pwm_r  output  1  right-motor PWM, registered.
- pwm_l  output  1  left-motor PWM, registered.
- duty_r  output  DUTY_W  current right duty.
- duty_l  output  DUTY_W  current left duty.
- busy  output  1  high while either duty differs from its target.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - pre=0, cnt=0, ramp=0, duty_r=duty_l=0, cmd_q=2'b11, pwm_r=pwm_l=0, busy=0.
  - Reset mid-ramp discards all progress.
  - After release, the block restarts from duty 0.
- Prescaler:
  - pre counts 0..PRESCALE-1 and wraps.
  - tick = (pre==PRESCALE-1).
- PWM counter:
  - cnt increments on tick and wraps 2^DUTY_W-1 → 0.
  - period_end = tick && cnt==2^DUTY_W-1.
- PWM outputs:
  - Each clock, pwm_x <= (cnt < duty_x), evaluated on the current registers, so there is a 1-clock lag.
  - Duty 0 gives a constant low.
  - Duty 2^DUTY_W-1 gives high for all but one count per period; 100% duty is not supported.
- Command targets ({right,left} → tgt_r, tgt_l):
  - 00 forward → DUTY_MAX, DUTY_MAX
  - 10 turn right → DUTY_MIN, DUTY_MAX
  - 01 turn left → DUTY_MAX, DUTY_MIN
  - 11 stop → 0, 0
- At period_end:
  - cmd_q <= {right,left}. Command changes that start and end between two period_ends are ignored.
  - ramp counts 0..RAMP_PERIODS-1 and wraps.
  - On the period_end where ramp==RAMP_PERIODS-1, each duty moves one step toward the target of the command sampled that same cycle. A duty already equal to its target holds.
  - Ramp arithmetic is unsigned and never over- or under-shoots the target.
- Duty timing:
  - duty_x changes only on period_end.
  - The new duty takes effect at cnt=0 of the next period.
- Busy:
  - busy = (duty_r != tgt(cmd_q).r) || (duty_l != tgt(cmd_q).l), registered.
  - busy updates on the same edge as duty and cmd_q.
- Command reversal mid-ramp: the ramp simply heads toward the new target from the current duty. No wait, no reset of the ramp counter.
- Command lines held at X are don't-care except at period_end.

Optional Feature:
- MOTOR_BRAKE_EN defined:
  - When the command sampled at period_end is 11 (stop), both duties go to 0 on that period_end, ignoring ramp position.
  - Leaving stop ramps up normally from 0.
- MOTOR_BRAKE_EN undefined: stop ramps down one step per ramp interval, like any other target.

Test Plan:
All scenarios use DUTY_W=3, PRESCALE=1, RAMP_PERIODS=1, DUTY_MAX=7, DUTY_MIN=2, giving an 8-clock period.
1. Release reset, hold {right,left}=00 -> duty_r/duty_l step 0,1,…,7 at successive period_ends (7 periods). busy=1 until both reach 7, then 0. pwm_x is high 7 of every 8 clocks.
2. From steady 7/7, apply 10 -> duty_r steps 7,6,5,4,3,2 over 5 period_ends while duty_l stays 7. Then apply 01 -> duty_r ramps to 7 and duty_l ramps to 2, both completing 5 period_ends after the change.
3. From steady 00, pulse right=1 for 3 clocks between period_ends -> cmd_q, duty and busy unchanged. Pulse covering a period_end -> cmd_q=10 and duty_r=6 after that edge.
4. Assert rst=0 mid-ramp at duty 4/4 and mid-period -> all outputs 0 within the same cycle, without a clock edge. After release, ramp restarts from 0.
5. Stop from 7/7: without MOTOR_BRAKE_EN -> duties reach 0 after 7 period_ends. With MOTOR_BRAKE_EN -> both duties are 0 after the first period_end and pwm_x stays low from the next period.
6. Duty 0 held for 3 periods -> pwm_x constantly 0. Check cnt wraps 7→0 and period_end is exactly one clock per 8.
